// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_LO = 2'd1,
        REQ_HI = 2'd2,
        PUSH   = 2'd3
    } fetch_state_t;

    localparam int INSTR_W     = 44;
    localparam int MEM_W       = 32;
    localparam int INSTR_BYTES = 8;
    localparam int HI_BITS     = 12;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Saturating 32-bit event counter used by the fetch performance monitors.
module fetch_perf_ctr (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetches 44-bit instructions as two 32-bit memory reads and pushes them into the queue.
// Optional counters perf_fetched / perf_full_stall are built when FETCH_PERF_CNT_EN is defined.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = 20,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                QUEUE_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [MEM_W-1:0]   mem_data,
    output logic [INSTR_W-1:0] q_d,
    output logic               q_we,
    input  logic [7:0]         q_used,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_full_stall,
`endif
    output fetch_state_t       dbg_state
);

    // Memory bus: mem_req is held with a stable mem_addr until a one-cycle mem_ack
    // (data valid that cycle). Queue: q_we is a one-cycle strobe, never issued while
    // q_used >= QUEUE_DEPTH.
    localparam logic [7:0] DEPTH_U = 8'(QUEUE_DEPTH);

    fetch_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                q_we_q, q_we_d;
    logic [INSTR_W-1:0]  q_d_q, q_d_d;
    logic [INSTR_W-1:0]  hold_q, hold_d;
    logic                redir_pend_q, redir_pend_d;
    logic                busy_q, busy_d;
    logic                full_stall;
    logic                q_full;
    logic [ADDR_W-1:0]   redirect_pc_al;

    assign q_full         = (q_used >= DEPTH_U);
    assign redirect_pc_al = {redirect_pc[ADDR_W-1:3], 3'b000};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        q_we_d       = 1'b0;
        q_d_d        = q_d_q;
        hold_d       = hold_q;
        redir_pend_d = redir_pend_q;
        full_stall   = 1'b0;

        if (redirect) begin
            pc_d = redirect_pc_al;
        end

        case (state_q)
            IDLE: begin
                if (redirect) begin
                    hold_d = '0;
                end
                if (en) begin
                    state_d    = REQ_LO;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_d;
                end
            end
            REQ_LO, REQ_HI: begin
                // A redirect cannot cancel an outstanding read; its data is dropped on ack.
                if (redirect) begin
                    redir_pend_d = 1'b1;
                end
                if (mem_ack) begin
                    if (redirect || redir_pend_q) begin
                        redir_pend_d = 1'b0;
                        hold_d       = '0;
                        state_d      = REQ_LO;
                        mem_addr_d   = pc_d;
                    end else if (state_q == REQ_LO) begin
                        hold_d[MEM_W-1:0] = mem_data;
                        mem_addr_d        = pc_q + ADDR_W'(MEM_W / 8);
                        state_d           = REQ_HI;
                    end else begin
                        hold_d[INSTR_W-1:MEM_W] = mem_data[HI_BITS-1:0];
                        mem_req_d               = 1'b0;
                        state_d                 = PUSH;
                    end
                end
            end
            PUSH: begin
                if (redirect) begin
                    hold_d     = '0;
                    state_d    = en ? REQ_LO : IDLE;
                    mem_req_d  = en;
                    mem_addr_d = pc_d;
                end else if (!q_full) begin
                    q_we_d     = 1'b1;
                    q_d_d      = hold_q;
                    pc_d       = pc_q + ADDR_W'(INSTR_BYTES);
                    state_d    = en ? REQ_LO : IDLE;
                    mem_req_d  = en;
                    mem_addr_d = pc_d;
                end else begin
                    full_stall = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= RESET_PC;
            q_we_q       <= 1'b0;
            q_d_q        <= '0;
            hold_q       <= '0;
            redir_pend_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            q_we_q       <= q_we_d;
            q_d_q        <= q_d_d;
            hold_q       <= hold_d;
            redir_pend_q <= redir_pend_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign q_we      = q_we_q;
    assign q_d       = q_d_q;
    assign pc        = pc_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

    logic unused_bits;
    assign unused_bits = ^{mem_data[MEM_W-1:HI_BITS], redirect_pc[2:0]};

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_ctr u_perf_fetched (
        .clk   (clk),
        .rst   (rst),
        .inc   (q_we_d),
        .count (perf_fetched)
    );

    fetch_perf_ctr u_perf_full_stall (
        .clk   (clk),
        .rst   (rst),
        .inc   (full_stall),
        .count (perf_full_stall)
    );
`else
    logic unused_perf;
    assign unused_perf = full_stall;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory responder, push scoreboard and address checks.
module tb_instruction_fetch;
    import fetch_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               redirect;
    logic [19:0]        redirect_pc;
    logic               mem_req;
    logic [19:0]        mem_addr;
    logic               mem_ack = 1'b0;
    logic [31:0]        mem_data = '0;
    logic [43:0]        q_d;
    logic               q_we;
    logic [7:0]         q_used;
    logic [19:0]        pc;
    logic               busy;
    fetch_state_t       dbg_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]        perf_fetched;
    logic [31:0]        perf_full_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [43:0] exp_q[$];
    logic [19:0] addr_q[$];
    logic [31:0] mem [logic [19:0]];

    logic [19:0] slow_addr = 20'h70000;
    int          slow_lat  = 0;
    int          wait_cnt  = 0;
    int          stray_cnt = 0;
    int          stray_done = 0;

    instruction_fetch #(
        .ADDR_W      (20),
        .RESET_PC    (20'h0),
        .QUEUE_DEPTH (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_data        (mem_data),
        .q_d             (q_d),
        .q_we            (q_we),
        .q_used          (q_used),
        .pc              (pc),
        .busy            (busy),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched    (perf_fetched),
        .perf_full_stall (perf_full_stall),
`endif
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [19:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    function automatic int lat_for(input logic [19:0] a);
        return (a == slow_addr) ? slow_lat : 0;
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || q_we) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n < 100), 64'd1);
    endtask

    // Memory responder: acks after lat_for(mem_addr) waiting cycles, checks each acked address.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (stray_cnt != stray_done) begin
            stray_done = stray_cnt;
            mem_ack    = 1'b1;
            mem_data   = 32'h5A5A_5A5A;
        end else if (rst || !mem_req) begin
            wait_cnt = 0;
        end else if (wait_cnt >= lat_for(mem_addr)) begin
            mem_ack  = 1'b1;
            mem_data = mem_read(mem_addr);
            wait_cnt = 0;
            if (addr_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL ack_addr: got request at %0h expected none", mem_addr);
            end else begin
                check("ack_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
            end
        end else begin
            wait_cnt++;
        end
    end

    // Push monitor: every q_we pops one expected instruction.
    always @(negedge clk) begin
        if (q_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL push_data: got push %0h expected none", q_d);
            end else begin
                check("push_data", 64'(q_d), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; redirect = 1'b0; redirect_pc = '0; q_used = '0;
        mem[20'h00000] = 32'hDEADBEEF;  mem[20'h00004] = 32'h00000ABC;
        mem[20'h00008] = 32'h12345678;  mem[20'h0000C] = 32'hFFFFF3C5;
        mem[20'h00010] = 32'hAAAA0001;  mem[20'h00014] = 32'h00000777;
        mem[20'h00100] = 32'hCAFEF00D;  mem[20'h00104] = 32'h00000421;
        mem[20'hFFFF8] = 32'h0BADC0DE;  mem[20'hFFFFC] = 32'h00000FED;

        repeat (3) @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'h0);
        check("rst_pc", 64'(pc), 64'h0);
        check("rst_q_we", 64'(q_we), 64'd0);
        check("rst_q_d", 64'(q_d), 64'h0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Basic fetch with immediate acks; en dropped while in REQ_LO.
        addr_q.push_back(20'h00000); addr_q.push_back(20'h00004);
        exp_q.push_back(44'hABC_DEADBEEF);
        en = 1'b1;
        @(negedge clk); en = 1'b0;
        check("t1_req", 64'(mem_req), 64'd1);
        check("t1_addr", 64'(mem_addr), 64'h0);
        check("t1_busy", 64'(busy), 64'd1);
        repeat (3) @(negedge clk);
        check("t1_q_we", 64'(q_we), 64'd1);
        check("t1_pc", 64'(pc), 64'h8);
        check("t1_busy_fall", 64'(busy), 64'd0);
        check("t1_req_low", 64'(mem_req), 64'd0);
        repeat (4) begin
            @(negedge clk);
            check("t1_quiet_req", 64'(mem_req), 64'd0);
            check("t1_quiet_we", 64'(q_we), 64'd0);
        end

        // Full queue blocks the push for five cycles.
        addr_q.push_back(20'h00008); addr_q.push_back(20'h0000C);
        exp_q.push_back(44'h3C5_12345678);
        q_used = 8'd8; en = 1'b1;
        @(negedge clk); en = 1'b0;
        @(negedge clk);
        repeat (6) begin
            @(negedge clk);
            check("t2_state", 64'(dbg_state), 64'(PUSH));
            check("t2_no_we", 64'(q_we), 64'd0);
            check("t2_q_d_stable", 64'(q_d), 64'hABC_DEADBEEF);
        end
        q_used = 8'd7;
        @(negedge clk);
        check("t2_q_we", 64'(q_we), 64'd1);
        check("t2_pc", 64'(pc), 64'h10);
`ifdef FETCH_PERF_CNT_EN
        check("t2_perf_stall", 64'(perf_full_stall), 64'd5);
        check("t2_perf_fetched", 64'(perf_fetched), 64'd2);
`endif
        @(negedge clk);
        check("t2_single_we", 64'(q_we), 64'd0);
        check("t2_idle", 64'(busy), 64'd0);
        q_used = 8'd0;

        // Redirect to 0x105 while the high word is outstanding.
        slow_addr = 20'h00014; slow_lat = 3;
        addr_q.push_back(20'h00010); addr_q.push_back(20'h00014);
        addr_q.push_back(20'h00100); addr_q.push_back(20'h00104);
        exp_q.push_back(44'h421_CAFEF00D);
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 20'h00105;
        @(negedge clk);
        redirect = 1'b0;
        check("t3_pc", 64'(pc), 64'h100);
        check("t3_addr_hold", 64'(mem_addr), 64'h14);
        check("t3_req_hold", 64'(mem_req), 64'd1);
        @(negedge clk);
        check("t3_addr_hold2", 64'(mem_addr), 64'h14);
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        check("t3_new_addr", 64'(mem_addr), 64'h100);
        check("t3_new_req", 64'(mem_req), 64'd1);
        check("t3_state", 64'(dbg_state), 64'(REQ_LO));
        wait_idle("t3_idle");
        check("t3_pc_end", 64'(pc), 64'h108);

        // Asynchronous reset during an outstanding request, then a stray ack.
        slow_addr = 20'h00108; slow_lat = 1000;
        en = 1'b1;
        @(negedge clk); en = 1'b0;
        check("t4_req", 64'(mem_req), 64'd1);
        check("t4_addr", 64'(mem_addr), 64'h108);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t4_rst_req", 64'(mem_req), 64'd0);
        check("t4_rst_pc", 64'(pc), 64'h0);
        check("t4_rst_addr", 64'(mem_addr), 64'h0);
        check("t4_rst_busy", 64'(busy), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); stray_cnt++;
        repeat (4) begin
            @(negedge clk);
            check("t4_stray_we", 64'(q_we), 64'd0);
            check("t4_stray_busy", 64'(busy), 64'd0);
            check("t4_stray_req", 64'(mem_req), 64'd0);
        end

        // Redirect from IDLE to the top of memory; pc wraps after the push.
        slow_addr = 20'h70000; slow_lat = 0;
        redirect = 1'b1; redirect_pc = 20'hFFFFF;
        @(negedge clk); redirect = 1'b0;
        check("t5_pc_align", 64'(pc), 64'hFFFF8);
        check("t5_idle", 64'(busy), 64'd0);
        check("t5_no_req", 64'(mem_req), 64'd0);
        addr_q.push_back(20'hFFFF8); addr_q.push_back(20'hFFFFC);
        exp_q.push_back(44'hFED_0BADC0DE);
        en = 1'b1;
        @(negedge clk); en = 1'b0;
        check("t5_addr_lo", 64'(mem_addr), 64'hFFFF8);
        @(negedge clk);
        check("t5_addr_hi", 64'(mem_addr), 64'hFFFFC);
        wait_idle("t5_idle_end");
        check("t5_pc_wrap", 64'(pc), 64'h0);

        repeat (3) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("addr_q_empty", 64'(addr_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
